// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage. Multiplies and divides are computed
// at accept time into temporaries, then committed to HI/LO after a fixed
// number of busy cycles so the pipeline sees the architectural latency.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic              dz_q, dz_d;

  logic [63:0]       prod_s, prod_u;
  logic [31:0]       a_mag, b_mag, q_mag, r_mag;
  logic [31:0]       quot_s, rem_s, quot_u, rem_u;
  logic              b_zero;

  // Arithmetic datapath; signed divide goes through magnitudes so the
  // INT_MIN / -1 corner simply wraps instead of trapping.
  always_comb begin
    b_zero = (B == 32'd0);
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
    r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
    quot_s = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = A[31] ? (~r_mag + 32'd1) : r_mag;
    quot_u = b_zero ? 32'd0 : (A / B);
    rem_u  = b_zero ? 32'd0 : (A % B);
  end

  // Next-state: accept in idle, count down in run, commit on the last cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (Start && !Req) begin
          case (MDUOp)
            4'd1: begin
              {hi_tmp_d, lo_tmp_d} = prod_s;
              dz_d    = 1'b0;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            4'd2: begin
              {hi_tmp_d, lo_tmp_d} = prod_u;
              dz_d    = 1'b0;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            4'd3: begin
              hi_tmp_d = rem_s;
              lo_tmp_d = quot_s;
              dz_d     = b_zero;
              cnt_d    = CntW'(DIV_CYCLES);
              state_d  = StRun;
            end
            4'd4: begin
              hi_tmp_d = rem_u;
              lo_tmp_d = quot_u;
              dz_d     = b_zero;
              cnt_d    = CntW'(DIV_CYCLES);
              state_d  = StRun;
            end
            4'd7:    hi_d = A;
            4'd8:    lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          // Divide by zero keeps HI/LO as they were.
          if (!dz_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset discarding any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs: Busy comes straight from state; mfhi/mflo read combinationally.
  always_comb begin
    Busy = (state_q == StRun);
    HI   = hi_q;
    LO   = lo_q;
    case (MDUOp)
      4'd5:    MDUOut = hi_q;
      4'd6:    MDUOut = lo_q;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized scoreboard bench for mdu with a plain-arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] MDUOut, HI, LO;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B), .Req(Req),
    .Busy(Busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] old_hi, old_lo, new_hi, new_lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result of an op from the architectural rules.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb_, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      4'd1: begin p = sa * sb_; hi = p[63:32]; lo = p[31:0]; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb_; r = sa % sb_; hi = r[31:0]; lo = q[31:0]; end
      4'd4: if (b != 0) begin hi = a % b; lo = a / b; end
      4'd7: hi = a;
      4'd8: lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op for a single cycle; busy_now says whether the unit is known busy.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic req, input logic busy_now);
    exp_t e;
    Start = (o != 4'd0); MDUOp = o; A = a; B = b; Req = req;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0; Req = 1'b0; A = $urandom; B = $urandom;
    if (!req && !busy_now) begin
      if (o >= 4'd1 && o <= 4'd4) begin
        e.old_hi = m_hi; e.old_lo = m_lo;
        model(o, a, b, m_hi, m_lo);
        e.new_hi = m_hi; e.new_lo = m_lo;
        e.cycles = (o <= 4'd2) ? 5 : 10;
        sb.push_back(e);
      end else begin
        model(o, a, b, m_hi, m_lo);
        chk("busy_after_nonmd", {31'd0, Busy}, 32'd0);
        chk("hi_after_op", HI, m_hi);
        chk("lo_after_op", LO, m_lo);
      end
    end else if (!busy_now) begin
      chk("hi_rejected", HI, m_hi);
      chk("lo_rejected", LO, m_lo);
      chk("busy_rejected", {31'd0, Busy}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin @(posedge clk); #1; n++; end
    if (Busy) begin
      errors++; checks++;
      $display("FAIL wait_idle actual=busy required=idle t=%0t", $time);
    end
  endtask

  task automatic rd(input logic [3:0] o);
    MDUOp = o; #1;
    chk(o == 4'd5 ? "mfhi" : "mflo", MDUOut, o == 4'd5 ? m_hi : m_lo);
    MDUOp = 4'd0;
  endtask

  // Monitor: tracks busy runs and checks HI/LO hold and final commit.
  int   run = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      run = 0; prev_busy = 1'b0;
    end else begin
      if (Busy) begin
        run++;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL busy_no_op actual=busy required=idle t=%0t", $time);
        end else begin
          chk("hold_hi", HI, sb[0].old_hi);
          chk("hold_lo", LO, sb[0].old_lo);
        end
      end else if (prev_busy && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("busy_len", run, e.cycles);
        chk("done_hi", HI, e.new_hi);
        chk("done_lo", LO, e.new_lo);
        run = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = 0; B = 0; Req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    // Directed cases.
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0); wait_idle();
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0); wait_idle();
    chk("multu_hi", HI, 32'h0000_0001);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0); wait_idle();
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b0); wait_idle();
    chk("divz_hi", HI, 32'hFFFF_FFFF);
    issue(4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    rd(4'd5);
    issue(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);

    // Start during busy cycle 3 is ignored.
    issue(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    issue(4'd8, 32'h5555_5555, 32'd3, 1'b0, 1'b1);
    wait_idle();
    chk("ign_hi", HI, 32'h4000_0000);
    issue(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);

    // Reset in busy cycle 4 of a divide.
    issue(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete(); m_hi = 32'd0; m_lo = 32'd0;
    repeat (12) begin
      chk("rstmid_busy", {31'd0, Busy}, 32'd0);
      chk("rstmid_hi", HI, 32'd0);
      chk("rstmid_lo", LO, 32'd0);
      @(posedge clk); #1;
    end

    // Randomized ops against the model.
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (o == 4'd5 || o == 4'd6) rd(o);
      else begin
        issue(o, a, b, ($urandom_range(0, 7) == 0), 1'b0);
        wait_idle();
      end
    end
    rd(4'd5);
    rd(4'd6);
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
